// File: rtl/econet_rx_pkg.sv
// Shared definitions for the Econet receive framer.
// Contents: FSM state encodings, HDLC line patterns, the FIFO entry layout
// {err, last, data[7:0]}, and a helper that packs an entry.
package econet_rx_pkg;

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_DATA    = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  localparam logic [7:0]  FLAG_PATTERN = 8'h7E;
  localparam int unsigned ABORT_ONES   = 7;

  localparam int unsigned ENTRY_W  = 10;
  localparam int unsigned ERR_BIT  = 9;
  localparam int unsigned LAST_BIT = 8;
  localparam int unsigned DATA_MSB = 7;

  typedef logic [ENTRY_W-1:0] rx_entry_t;

  function automatic rx_entry_t make_entry(input logic err, input logic last,
                                           input logic [7:0] data);
    return {err, last, data};
  endfunction

endpackage

// File: rtl/econet_rx_if.sv
// Host-side byte stream of the Econet receive framer.
// Signals: rx_data/rx_last/rx_err describe the FIFO head, rx_valid flags a
// non-empty FIFO, rx_ready is the consumer pop request.
// Modports: master = framer (drives head), slave = consumer (drives ready).
interface econet_rx_if;
  logic [7:0] rx_data;
  logic       rx_last;
  logic       rx_err;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_last, output rx_err,
                  output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_last, input rx_err,
                  input rx_valid, output rx_ready);
endinterface

// File: rtl/econet_rx_fifo.sv
// First-word fall-through FIFO for framer entries.
// Ports: clk, reset (async, active-high), push/push_data write side,
// pop read side, head (current entry, zero when empty), full, empty.
// A push while full is accepted only when a pop happens in the same cycle.
module econet_rx_fifo
  import econet_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic               do_push;
  logic               do_pop;

  // Extra MSB on each pointer distinguishes full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/econet_rx_framer.sv
// Econet receive framing controller.
// Watches the raw line for HDLC flags (0x7E) and aborts (7 ones), realigns the
// external bit-unstuffing deserializer with deser_clear, collects its bytes and
// queues them with frame last/error markers for the host.
// Ports: clk, reset (async, active-high), enable, line_bit, deser_data,
// deser_strobe, deser_clear (out), rx (host stream, master side),
// rx_overrun (dropped-push pulse), in_frame (state DATA).
module econet_rx_framer
  import econet_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MIN_LEN    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             line_bit,
  input  logic [7:0]       deser_data,
  input  logic             deser_strobe,
  output logic             deser_clear,
  econet_rx_if.master      rx,
  output logic             rx_overrun,
  output logic             in_frame
);

  // Only the seven most recent line bits are kept; the current bit completes
  // the 8-bit window.
  logic [6:0] line_sr;
  logic [7:0] win;
  logic       flag_hit;
  logic       abort_hit;

  logic       strobe_q;
  logic       clear_q;
  logic       byte_done;

  logic [1:0] state, state_nx;
  logic [7:0] hold, hold_nx;
  logic       hold_full, hold_full_nx;
  logic [7:0] count, count_nx;

  logic       push;
  rx_entry_t  push_entry;
  rx_entry_t  head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       drop;

  assign win       = {line_sr, line_bit};
  assign abort_hit = (win[ABORT_ONES-1:0] == '1);
  assign flag_hit  = ~abort_hit && (win == FLAG_PATTERN);

  // Count wrap 7->0 marks a finished byte; wraps forced by our own clear
  // (this cycle or the one before) are not real bytes.
  assign byte_done = strobe_q & ~deser_strobe & ~deser_clear & ~clear_q;

  assign pop  = rx.rx_valid & rx.rx_ready;
  assign drop = push & fifo_full & ~pop;

  always_comb begin
    state_nx     = state;
    hold_nx      = hold;
    hold_full_nx = hold_full;
    count_nx     = count;
    push         = 1'b0;
    push_entry   = '0;
    if (!enable) begin
      state_nx     = ST_HUNT;
      hold_full_nx = 1'b0;
      if (state == ST_DATA && hold_full) begin
        push       = 1'b1;
        push_entry = make_entry(1'b1, 1'b1, hold);
      end
    end else begin
      case (state)
        ST_HUNT: if (flag_hit) state_nx = ST_IDLE;
        ST_IDLE: begin
          if (abort_hit) begin
            state_nx = ST_HUNT;
          end else if (!flag_hit && byte_done) begin
            hold_nx      = deser_data;
            hold_full_nx = 1'b1;
            count_nx     = 8'd1;
            state_nx     = ST_DATA;
          end
        end
        ST_DATA: begin
          if (abort_hit) begin
            push         = hold_full;
            push_entry   = make_entry(1'b1, 1'b1, hold);
            hold_full_nx = 1'b0;
            state_nx     = ST_HUNT;
          end else if (flag_hit) begin
            push         = hold_full;
            push_entry   = make_entry(32'(count) < MIN_LEN, 1'b1, hold);
            hold_full_nx = 1'b0;
            state_nx     = ST_IDLE;
          end else if (byte_done) begin
            push         = hold_full;
            push_entry   = make_entry(1'b0, 1'b0, hold);
            hold_nx      = deser_data;
            hold_full_nx = 1'b1;
            if (count != 8'hFF) count_nx = count + 8'd1;
          end
        end
        ST_DISCARD: begin
          if (abort_hit)     state_nx = ST_HUNT;
          else if (flag_hit) state_nx = ST_IDLE;
        end
        default: state_nx = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_sr     <= '0;
      strobe_q    <= 1'b0;
      clear_q     <= 1'b0;
      deser_clear <= 1'b0;
      state       <= ST_HUNT;
      hold        <= '0;
      hold_full   <= 1'b0;
      count       <= '0;
      rx_overrun  <= 1'b0;
    end else begin
      line_sr     <= win[6:0];
      strobe_q    <= deser_strobe;
      clear_q     <= deser_clear;
      deser_clear <= flag_hit | abort_hit;
      hold        <= hold_nx;
      count       <= count_nx;
      rx_overrun  <= drop;
      // A dropped push abandons the rest of the frame until the next flag.
      if (drop && enable) begin
        state     <= ST_DISCARD;
        hold_full <= 1'b0;
      end else begin
        state     <= state_nx;
        hold_full <= hold_full_nx;
      end
    end
  end

  econet_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (rx.rx_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx.rx_data  = head[DATA_MSB:0];
  assign rx.rx_last  = head[LAST_BIT];
  assign rx.rx_err   = head[ERR_BIT];
  assign rx.rx_valid = ~fifo_empty;
  assign in_frame    = (state == ST_DATA);

endmodule
